// File: rtl/fifo_reader.sv
// Read engine that drains a synchronous FIFO into a 3-entry in-order buffer
// and presents the words downstream on a valid/ready handshake.
module fifo_reader #(
  parameter int FIFO_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  output logic                  fifo_rd_en,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [15:0]           rd_count,
  output logic                  underflow_err,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  state_t                state_r;
  state_t                state_s;
  logic [1:0]            occ_r;
  logic [1:0]            occ_s;
  logic                  inflight_r;
  logic                  valid_r;
  logic                  busy_r;
  logic [15:0]           count_r;
  logic                  uf_err_r;
  logic [FIFO_WIDTH-1:0] entry_r [3];
  logic [FIFO_WIDTH-1:0] entry_s [3];
  logic                  pop_s;
  logic                  cap_s;
  logic                  uf_s;
  logic [1:0]            wr_idx_s;

  // A strobe is only issued when every outstanding word is guaranteed a slot.
  assign fifo_rd_en = (state_r == ACTIVE) && !fifo_empty &&
                      (({1'b0, occ_r} + {2'b00, inflight_r}) < 3'd3);

  assign m_data        = entry_r[0];
  assign m_valid       = valid_r;
  assign rd_count      = count_r;
  assign underflow_err = uf_err_r;
  assign busy          = busy_r;

  // Buffer datapath: head lives in entry 0; a pop shifts toward the head.
  always_comb begin
    pop_s    = valid_r && m_ready;
    cap_s    = inflight_r && !fifo_underflow;
    uf_s     = inflight_r && fifo_underflow;
    entry_s  = entry_r;
    wr_idx_s = occ_r;
    if (pop_s) begin
      entry_s[0] = entry_r[1];
      entry_s[1] = entry_r[2];
      wr_idx_s   = occ_r - 2'd1;
    end else begin
      wr_idx_s   = occ_r;
    end
    if (cap_s) begin
      case (wr_idx_s)
        2'd0:    entry_s[0] = fifo_data_out;
        2'd1:    entry_s[1] = fifo_data_out;
        2'd2:    entry_s[2] = fifo_data_out;
        default: entry_s[2] = entry_s[2];
      endcase
    end else begin
      entry_s[0] = entry_s[0];
    end
    case ({cap_s, pop_s})
      2'b10:   occ_s = occ_r + 2'd1;
      2'b01:   occ_s = occ_r - 2'd1;
      default: occ_s = occ_r;
    endcase
  end

  // Next-state logic; en takes priority over finishing a flush.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (en) state_s = ACTIVE;
        else    state_s = IDLE;
      end
      ACTIVE: begin
        if (!en) state_s = FLUSH;
        else     state_s = ACTIVE;
      end
      FLUSH: begin
        if (en)                                state_s = ACTIVE;
        else if (occ_r == 2'd0 && !inflight_r) state_s = IDLE;
        else                                   state_s = FLUSH;
      end
      default: state_s = IDLE;
    endcase
  end

  // State, buffer and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      occ_r      <= 2'd0;
      inflight_r <= 1'b0;
      valid_r    <= 1'b0;
      busy_r     <= 1'b0;
      count_r    <= 16'd0;
      uf_err_r   <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        entry_r[i] <= '0;
      end
    end else begin
      state_r    <= state_s;
      occ_r      <= occ_s;
      inflight_r <= fifo_rd_en;
      valid_r    <= (occ_s != 2'd0);
      busy_r     <= (state_s != IDLE);
      entry_r    <= entry_s;
      if (cap_s) count_r <= count_r + 16'd1;
      else       count_r <= count_r;
      if (uf_s)  uf_err_r <= 1'b1;
      else       uf_err_r <= uf_err_r;
    end
  end

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader: behavioural FIFO plus an in-order
// scoreboard of captured words, directed vectors and random traffic.
module tb_fifo_reader;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        fifo_rd_en;
  logic [15:0] fifo_data_out;
  logic        fifo_empty;
  logic        fifo_underflow;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] rd_count;
  logic        underflow_err;
  logic        busy;

  fifo_reader #(.FIFO_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .fifo_rd_en(fifo_rd_en), .fifo_data_out(fifo_data_out),
    .fifo_empty(fifo_empty), .fifo_underflow(fifo_underflow),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .rd_count(rd_count), .underflow_err(underflow_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        rdy;
    logic        rd_en;
    logic        valid;
    logic [15:0] data;
    logic [15:0] count;
    logic        busy;
  } vec_t;

  logic [15:0] fq[$];
  logic [15:0] sb[$];
  logic        rd_pend, cap_good, uf_cap, uf_inject, exp_uf, prev_en;
  logic [15:0] cap_word, cnt;
  logic        s_rd_en, s_valid, s_busy, s_uf, s_pop;
  logic [15:0] s_data, s_count;
  int          total, bad;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock cycle: deliver last read, drive inputs, sample, advance model.
  task automatic cycle(input logic en_v, input logic rdy_v);
    logic [15:0] w;
    @(negedge clk);
    fifo_underflow = 1'b0;
    if (rd_pend) begin
      rd_pend = 1'b0;
      if (uf_inject || fq.size() == 0) begin
        uf_inject      = 1'b0;
        fifo_underflow = 1'b1;
        fifo_data_out  = 16'($urandom);
        uf_cap         = 1'b1;
      end else begin
        w             = fq.pop_front();
        fifo_data_out = w;
        cap_word      = w;
        cap_good      = 1'b1;
      end
    end
    fifo_empty = (fq.size() == 0);
    en      = en_v;
    m_ready = rdy_v;
    #1;
    s_rd_en = fifo_rd_en; s_valid = m_valid; s_data = m_data;
    s_count = rd_count;   s_busy = busy;     s_uf = underflow_err;
    chk("m_valid", 32'(s_valid), 32'(sb.size() != 0));
    if (sb.size() != 0) chk("m_data", 32'(s_data), 32'(sb[0]));
    chk("rd_count", 32'(s_count), 32'(cnt));
    chk("underflow_err", 32'(s_uf), 32'(exp_uf));
    chk("rd_en_when_empty", 32'(s_rd_en && fifo_empty), 32'd0);
    if (s_rd_en) chk("strobe_needs_en", 32'(prev_en), 32'd1);
    prev_en = en_v;
    rd_pend = s_rd_en;
    s_pop   = s_valid && rdy_v;
    if (s_pop && sb.size() != 0) void'(sb.pop_front());
    if (cap_good) begin sb.push_back(cap_word); cnt = cnt + 16'd1; cap_good = 1'b0; end
    if (uf_cap) begin exp_uf = 1'b1; uf_cap = 1'b0; end
    chk("outstanding", 32'((sb.size() + 32'(rd_pend)) <= 3), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_rd_count", 32'(rd_count), 32'd0);
    chk("rst_underflow_err", 32'(underflow_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fifo_rd_en", 32'(fifo_rd_en), 32'd0);
    sb.delete();
    rd_pend = 1'b0; cap_good = 1'b0; uf_cap = 1'b0; uf_inject = 1'b0;
    exp_uf = 1'b0; prev_en = 1'b0; cnt = 16'd0;
    fifo_underflow = 1'b0;
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic push_words(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) fq.push_back(base + 16'(i));
  endtask

  initial begin
    vec_t tbl[7];
    int   strobes, pops, guard, fs;
    logic idle, en_mode;

    total = 0; bad = 0;
    rst_n = 1'b0; en = 1'b0; m_ready = 1'b0; fifo_empty = 1'b1;
    fifo_underflow = 1'b0; fifo_data_out = 16'd0; cnt = 16'd0;
    rd_pend = 1'b0; cap_good = 1'b0; uf_cap = 1'b0; uf_inject = 1'b0;
    exp_uf = 1'b0; prev_en = 1'b0; cap_word = 16'd0;

    //            en    rdy   rd_en valid data      count  busy
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'd0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'd0, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'd0, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h00A1, 16'd1, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h00A2, 16'd2, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h00A3, 16'd3, 1'b1};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'd3, 1'b1};

    // Three-word stream with m_ready high.
    do_reset();
    fq.delete();
    push_words(16'h00A1, 3);
    for (int i = 0; i < 7; i++) begin
      cycle(tbl[i].en, tbl[i].rdy);
      chk($sformatf("vec%0d_rd_en", i), 32'(s_rd_en), 32'(tbl[i].rd_en));
      chk($sformatf("vec%0d_valid", i), 32'(s_valid), 32'(tbl[i].valid));
      chk($sformatf("vec%0d_count", i), 32'(s_count), 32'(tbl[i].count));
      chk($sformatf("vec%0d_busy", i), 32'(s_busy), 32'(tbl[i].busy));
      if (tbl[i].valid) chk($sformatf("vec%0d_data", i), 32'(s_data), 32'(tbl[i].data));
    end

    // Backpressure: buffer fills, strobes stop, head holds.
    do_reset();
    fq.delete();
    push_words(16'h00A1, 5);
    strobes = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0);
      if (s_rd_en) strobes++;
    end
    chk("stall_strobes", 32'(strobes), 32'd3);
    chk("stall_rd_en", 32'(s_rd_en), 32'd0);
    chk("stall_head", 32'(s_data), 32'h00A1);
    pops = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b1);
      if (s_pop) pops++;
    end
    chk("stall_drain_pops", 32'(pops), 32'd5);

    // Underflow on a read: word dropped, sticky error.
    do_reset();
    fq.delete();
    push_words(16'h0B01, 2);
    uf_inject = 1'b1;
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1);
    chk("uf_sticky", 32'(s_uf), 32'd1);
    chk("uf_count", 32'(s_count), 32'd2);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1);
    chk("uf_still_set", 32'(s_uf), 32'd1);

    // Flush with occ=2 and one read in flight.
    do_reset();
    fq.delete();
    push_words(16'h0C01, 5);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    chk("flush_entry_valid", 32'(s_valid), 32'd1);
    fs = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0);
      chk("flush_hold_busy", 32'(s_busy), 32'd1);
      if (s_rd_en) fs++;
    end
    pops = 0; idle = 1'b0;
    for (int i = 0; i < 12 && !idle; i++) begin
      cycle(1'b0, 1'b1);
      if (pops < 3) chk("flush_busy", 32'(s_busy), 32'd1);
      else if (!s_busy) idle = 1'b1;
      if (s_pop) pops++;
      if (s_rd_en) fs++;
    end
    chk("flush_pops", 32'(pops), 32'd3);
    chk("flush_idle", 32'(s_busy), 32'd0);
    chk("flush_no_strobe", 32'(fs), 32'd0);
    chk("flush_fifo_left", 32'(fq.size()), 32'd2);

    // Reset mid-stream with occ=2.
    do_reset();
    fq.delete();
    push_words(16'h0D01, 5);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0);
    chk("pre_reset_valid", 32'(s_valid), 32'd1);
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
    chk("post_reset_valid", 32'(s_valid), 32'd0);

    // Random traffic against the scoreboard.
    en_mode = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 1) == 0 && fq.size() < 8) fq.push_back(16'($urandom));
      if ($urandom_range(0, 60) == 0) uf_inject = 1'b1;
      if ($urandom_range(0, 30) == 0) en_mode = ~en_mode;
      cycle(en_mode, $urandom_range(0, 3) != 0);
      if (i == 1500) do_reset();
    end

    // Sustained streaming, then rd_count wrap.
    do_reset();
    fq.delete();
    for (int i = 0; i < 10; i++) begin
      if (fq.size() < 4) fq.push_back(16'($urandom));
      cycle(1'b1, 1'b1);
    end
    pops = 0;
    for (int i = 0; i < 32; i++) begin
      if (fq.size() < 4) fq.push_back(16'($urandom));
      cycle(1'b1, 1'b1);
      if (s_pop) pops++;
    end
    chk("throughput", 32'(pops), 32'd32);
    guard = 0;
    while (cnt != 16'hFFFF && guard < 70000) begin
      if (fq.size() < 4) fq.push_back(16'($urandom));
      cycle(1'b1, 1'b1);
      guard++;
    end
    chk("wrap_reach_timeout", 32'(guard < 70000), 32'd1);
    if (fq.size() < 4) fq.push_back(16'($urandom));
    cycle(1'b1, 1'b1);
    chk("rd_count_ffff", 32'(s_count), 32'hFFFF);
    guard = 0;
    while (cnt != 16'h0000 && guard < 20) begin
      if (fq.size() < 4) fq.push_back(16'($urandom));
      cycle(1'b1, 1'b1);
      guard++;
    end
    chk("wrap_zero_timeout", 32'(guard < 20), 32'd1);
    cycle(1'b1, 1'b1);
    chk("rd_count_wrap", 32'(s_count), 32'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 The block SHALL have parameter FIFO_WIDTH, default 16, which sets the data word width.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port en, input, 1 bit: read-engine enable.
REQ-005 The block SHALL have port fifo_rd_en, output, 1 bit: read strobe to the sync FIFO.
REQ-006 The block SHALL have port fifo_data_out, input, FIFO_WIDTH bits: FIFO read data, valid the cycle after an accepted fifo_rd_en.
REQ-007 The block SHALL have port fifo_empty, input, 1 bit: FIFO empty flag.
REQ-008 The block SHALL have port fifo_underflow, input, 1 bit: FIFO underflow flag for the read issued the previous cycle.
REQ-009 The block SHALL have port m_data, output, FIFO_WIDTH bits: downstream data.
REQ-010 The block SHALL have port m_valid, output, 1 bit: downstream valid.
REQ-011 The block SHALL have port m_ready, input, 1 bit: downstream ready.
REQ-012 The block SHALL have port rd_count, output, 16 bits: count of words captured from the FIFO.
REQ-013 The block SHALL have port underflow_err, output, 1 bit: sticky underflow error.
REQ-014 The block SHALL have port busy, output, 1 bit: high when state is not IDLE.

Function
REQ-015 The block SHALL hold a 3-entry in-order buffer (occ 0..3) and one in-flight bit (inflight = fifo_rd_en registered).
REQ-016 fifo_rd_en SHALL equal (state==ACTIVE) && !fifo_empty && (occ + inflight < 3), computed combinationally from registered state.
REQ-017 On each rising edge with inflight=1 and fifo_underflow=0, the block SHALL write fifo_data_out at the buffer tail and increment rd_count.
REQ-018 On each rising edge with inflight=1 and fifo_underflow=1, the block SHALL discard the word, set underflow_err, and leave rd_count unchanged.
REQ-019 m_valid SHALL equal (occ!=0), and m_data SHALL present the buffer head.
REQ-020 A pop SHALL occur on any edge where m_valid && m_ready; a pop and a capture in the same cycle SHALL leave occ unchanged.
REQ-021 While m_valid && !m_ready, m_data SHALL remain stable.
REQ-022 Words SHALL leave the block in exactly FIFO read order, with no loss or duplication.
REQ-023 The latency from fifo_rd_en high to the corresponding m_valid high SHALL be 2 cycles.
REQ-024 With the FIFO non-empty and m_ready held high, the block SHALL sustain one word per cycle.
REQ-025 The state machine SHALL have states IDLE, ACTIVE and FLUSH.
REQ-026 State IDLE SHALL move to ACTIVE on en=1.
REQ-027 State ACTIVE SHALL move to FLUSH on en=0.
REQ-028 State FLUSH SHALL issue no fifo_rd_en, SHALL still capture any in-flight word, and SHALL keep presenting buffered words.
REQ-029 State FLUSH SHALL move to IDLE when occ==0 && inflight==0, and SHALL return to ACTIVE if en=1 (en has priority).
REQ-030 rd_count SHALL wrap from 0xFFFF to 0x0000.
REQ-031 underflow_err SHALL be cleared only by reset.
REQ-032 busy SHALL equal (state!=IDLE).

Reset
REQ-033 Asserting rst_n=0 SHALL immediately and asynchronously force: state=IDLE, occ=0, inflight=0, m_valid=0, m_data=0, fifo_rd_en=0, rd_count=0, underflow_err=0, busy=0.
REQ-034 A reset mid-operation SHALL discard buffered and in-flight words, and no capture SHALL occur on the first edge after release.
REQ-035 After rst_n deasserts, the block SHALL stay in IDLE until it samples en=1.

Verification
REQ-036 Reset, en=1, FIFO holds 0x00A1/0x00A2/0x00A3, m_ready=1 -> fifo_rd_en high 3 consecutive cycles; m_valid 2 cycles after the first strobe; words out on consecutive cycles in order; rd_count=3.
REQ-037 m_ready=0, FIFO holds 5 words -> exactly 3 strobes then fifo_rd_en=0; m_data holds 0x00A1; after m_ready=1, all 5 words out in order.
REQ-038 fifo_underflow=1 in the cycle after a strobe -> no buffer write; underflow_err=1 and stays 1; rd_count unchanged.
REQ-039 en dropped with occ=2 and inflight=1 -> no new strobe; busy=1 until 3 words popped; then state IDLE and busy=0.
REQ-040 rst_n pulsed low mid-stream with occ=2 -> m_valid=0 and rd_count=0 before the next clk edge; no stale word after release.
REQ-041 rd_count preloaded to 0xFFFF via 65535 captures, then one more capture -> rd_count=0x0000.
